// File: rtl/wb_pkg.sv
// Shared types and widths for the Wishbone scratchpad slave.
package wb_pkg;

    localparam int WB_DW   = 64;
    localparam int WB_SELW = 8;
    localparam int WB_TGW  = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } wb_slv_state_e;

    typedef enum logic [1:0] {
        RSP_ACK,
        RSP_ERR,
        RSP_RTY
    } wb_rsp_e;

    // Expand byte-lane enables into a full-width bit mask.
    function automatic logic [WB_DW-1:0] lane_mask(input logic [WB_SELW-1:0] sel);
        logic [WB_DW-1:0] m;
        m = '0;
        for (int i = 0; i < WB_SELW; i++) begin
            m[8*i +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_slave_mem_if.sv
// Wishbone B4 classic bus bundle between one master and the memory slave.
interface wb_slave_mem_if;
    import wb_pkg::*;

    logic [63:0]         ADR_I;
    logic [WB_DW-1:0]    DAT_I;
    logic [WB_DW-1:0]    DAT_O;
    logic [WB_SELW-1:0]  SEL_I;
    logic                WE_I;
    logic                CYC_I;
    logic                STB_I;
    logic                LOCK_I;
    logic [WB_TGW-1:0]   TGD_I;
    logic [WB_TGW-1:0]   TGD_O;
    logic                ACK_O;
    logic                ERR_O;
    logic                RTY_O;

    modport slave (
        input  ADR_I, DAT_I, SEL_I, WE_I, CYC_I, STB_I, LOCK_I, TGD_I,
        output DAT_O, TGD_O, ACK_O, ERR_O, RTY_O
    );

    modport master (
        output ADR_I, DAT_I, SEL_I, WE_I, CYC_I, STB_I, LOCK_I, TGD_I,
        input  DAT_O, TGD_O, ACK_O, ERR_O, RTY_O
    );

endinterface

// File: rtl/wb_slave_mem_array.sv
// Single-port synchronous RAM, 64-bit words with per-byte write enables.
module wb_slave_mem_array
    import wb_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               en_i,
    input  logic               we_i,
    input  logic [AW-1:0]      addr_i,
    input  logic [WB_SELW-1:0] be_i,
    input  logic [WB_DW-1:0]   wdata_i,
    output logic [WB_DW-1:0]   rdata_o
);

    logic [WB_DW-1:0] mem_q [DEPTH];
    logic [WB_DW-1:0] rdata_q;

    // Byte-lane write or registered read; read data holds between reads.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < WB_SELW; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone classic slave fronting a byte-lane RAM with address decode,
// programmable wait states and ACK/ERR/RTY termination.
module wb_slave_mem
    import wb_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter int          WAIT_STATES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          busy,
    wb_slave_mem_if.slave wb
);

    localparam int         AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    wb_slv_state_e       state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [WB_SELW-1:0]  sel_q;
    logic [WB_DW-1:0]    dat_q;
    logic [AW-1:0]       idx_q;
    logic [WB_TGW-1:0]   tgd_q;
    logic                ack_q, ack_d, err_q, err_d, rty_q, rty_d;
    logic                rd_valid_q, rd_valid_d;
    logic [WB_SELW-1:0]  rd_sel_q, rd_sel_d;
    logic                latch;

    logic [63:0]         off;
    logic                adr_err;
    logic [AW-1:0]       idx_in;
    wb_rsp_e             rsp_kind;

    logic                mem_en, mem_we;
    logic [AW-1:0]       mem_idx;
    logic [WB_SELW-1:0]  mem_sel;
    logic [WB_DW-1:0]    mem_wdata, mem_rdata;

    assign off     = wb.ADR_I - BASE_ADDR;
    assign adr_err = (wb.ADR_I[2:0] != 3'b000) || (wb.ADR_I < BASE_ADDR) ||
                     ((off >> 3) >= 64'(DEPTH));
    assign idx_in  = AW'(off >> 3);
    assign rsp_kind = adr_err             ? RSP_ERR :
                      (busy && !wb.LOCK_I) ? RSP_RTY : RSP_ACK;

    // Next-state, response strobes and RAM access control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rty_d      = 1'b0;
        rd_valid_d = rd_valid_q;
        rd_sel_d   = rd_sel_q;
        latch      = 1'b0;
        mem_en     = 1'b0;
        mem_we     = we_q;
        mem_idx    = idx_q;
        mem_sel    = sel_q;
        mem_wdata  = dat_q;
        case (state_q)
            IDLE: begin
                if (wb.CYC_I && wb.STB_I) begin
                    latch = 1'b1;
                    case (rsp_kind)
                        RSP_ERR: begin
                            err_d      = 1'b1;
                            rd_valid_d = 1'b0;
                            state_d    = RESP;
                        end
                        RSP_RTY: begin
                            rty_d      = 1'b1;
                            rd_valid_d = 1'b0;
                            state_d    = RESP;
                        end
                        default: begin
                            if (WAIT_STATES == 0) begin
                                // No wait states: access straight from the bus.
                                mem_en     = 1'b1;
                                mem_we     = wb.WE_I;
                                mem_idx    = idx_in;
                                mem_sel    = wb.SEL_I;
                                mem_wdata  = wb.DAT_I;
                                ack_d      = 1'b1;
                                rd_valid_d = !wb.WE_I;
                                rd_sel_d   = wb.SEL_I;
                                state_d    = RESP;
                            end else begin
                                cnt_d   = WS;
                                state_d = WAIT;
                            end
                        end
                    endcase
                end
            end
            WAIT: begin
                if (!wb.CYC_I) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd1) begin
                    mem_en     = 1'b1;
                    ack_d      = 1'b1;
                    rd_valid_d = !we_q;
                    rd_sel_d   = sel_q;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A reset edge must never commit a pending write.
        if (!rst) begin
            mem_en = 1'b0;
        end
    end

    // State, counter, latched request and response registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            dat_q      <= '0;
            idx_q      <= '0;
            tgd_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rty_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_sel_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rty_q      <= rty_d;
            rd_valid_q <= rd_valid_d;
            rd_sel_q   <= rd_sel_d;
            if (latch) begin
                we_q  <= wb.WE_I;
                sel_q <= wb.SEL_I;
                dat_q <= wb.DAT_I;
                idx_q <= idx_in;
                tgd_q <= wb.TGD_I;
            end
        end
    end

    wb_slave_mem_array #(.DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .addr_i  (mem_idx),
        .be_i    (mem_sel),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    assign wb.ACK_O = ack_q;
    assign wb.ERR_O = err_q;
    assign wb.RTY_O = rty_q;
    assign wb.TGD_O = tgd_q;
    assign wb.DAT_O = rd_valid_q ? (mem_rdata & lane_mask(rd_sel_q)) : '0;

endmodule
